// File: rtl/fifo_arb_pkg.sv
// Shared constants and FSM encoding for the FIFO write arbiter.
//   DEF_*        : default parameter values for fifo_write_arbiter
//   arb_state_e  : two-state arbiter FSM encoding
package fifo_arb_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 64;
  localparam int unsigned DEF_NUM_REQ     = 4;
  localparam int unsigned DEF_REQ_ID_BITS = 2;
  localparam int unsigned DEF_MAX_BURST   = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first valid requester strictly after
// last_grant, wrapping modulo NUM_REQ (last_grant itself is checked last).
//   valid      : per-requester request vector
//   last_grant : most recently granted index
//   next_id    : chosen index (0 when nothing is valid)
//   any_valid  : at least one request present
module rr_priority_picker #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned REQ_ID_BITS = 2
) (
  input  logic [NUM_REQ-1:0]     valid,
  input  logic [REQ_ID_BITS-1:0] last_grant,
  output logic [REQ_ID_BITS-1:0] next_id,
  output logic                   any_valid
);

  int unsigned idx;

  always_comb begin
    next_id   = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = 32'(last_grant) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_valid && valid[idx]) begin
        any_valid = 1'b1;
        next_id   = REQ_ID_BITS'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter multiplexing NUM_REQ burst writers onto one FIFO
// write port. A grant is decided in an IDLE cycle; the holder then streams
// up to MAX_BURST words with zero-latency pass-through, stalling on full.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   req_valid_i     : per-requester word available
//   req_data_i      : packed requester words, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_ready_o     : accept flag for the grant holder (combinational)
//   fifo_full_i     : FIFO full
//   fifo_wr_en_o    : FIFO write strobe (combinational)
//   fifo_data_o     : FIFO write word, zero when not writing
//   grant_id_o      : registered grant index
//   busy_o          : grant held
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned REQ_ID_BITS = DEF_REQ_ID_BITS,
  parameter int unsigned MAX_BURST   = DEF_MAX_BURST
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic [REQ_ID_BITS-1:0]        grant_id_o,
  output logic                          busy_o
);

  localparam int unsigned BEAT_W = $clog2(MAX_BURST) + 1;

  arb_state_e             state;
  logic [REQ_ID_BITS-1:0] grant_id;
  logic [REQ_ID_BITS-1:0] last_grant;
  logic [BEAT_W-1:0]      beat_cnt;

  logic [REQ_ID_BITS-1:0] pick_id;
  logic                   pick_any;
  logic                   holder_valid;
  logic                   in_burst;
  logic                   xfer;

  rr_priority_picker #(
    .NUM_REQ     (NUM_REQ),
    .REQ_ID_BITS (REQ_ID_BITS)
  ) u_picker (
    .valid      (req_valid_i),
    .last_grant (last_grant),
    .next_id    (pick_id),
    .any_valid  (pick_any)
  );

  // Outputs are forced low while reset is asserted, even mid-burst.
  always_comb begin
    req_ready_o  = '0;
    fifo_data_o  = '0;
    holder_valid = req_valid_i[grant_id];
    in_burst     = (state == BURST) && !rst_i;
    xfer         = in_burst && holder_valid && !fifo_full_i;
    if (in_burst) req_ready_o[grant_id] = !fifo_full_i;
    if (xfer) fifo_data_o = req_data_i[DATA_WIDTH*grant_id +: DATA_WIDTH];
    fifo_wr_en_o = xfer;
    busy_o       = in_burst;
    grant_id_o   = rst_i ? '0 : grant_id;
  end

  // Grant FSM: grant decided in IDLE, burst ends on length or release.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= REQ_ID_BITS'(NUM_REQ - 1);
      grant_id   <= '0;
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id   <= pick_id;
            last_grant <= pick_id;
            beat_cnt   <= '0;
            state      <= BURST;
          end
        end
        BURST: begin
          if (!holder_valid) begin
            state <= IDLE;
          end else if (!fifo_full_i) begin
            if (beat_cnt == BEAT_W'(MAX_BURST - 1)) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model.
module tb_fifo_write_arbiter;

  localparam int DW = 64;
  localparam int NR = 4;
  localparam int IB = 2;
  localparam int MB = 8;

  logic             clk_i;
  logic             rst_i;
  logic [NR-1:0]    req_valid_i;
  logic [NR*DW-1:0] req_data_i;
  logic [NR-1:0]    req_ready_o;
  logic             fifo_full_i;
  logic             fifo_wr_en_o;
  logic [DW-1:0]    fifo_data_o;
  logic [IB-1:0]    grant_id_o;
  logic             busy_o;

  fifo_write_arbiter #(
    .DATA_WIDTH (DW), .NUM_REQ (NR), .REQ_ID_BITS (IB), .MAX_BURST (MB)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_ready_o  (req_ready_o),
    .fifo_full_i  (fifo_full_i),
    .fifo_wr_en_o (fifo_wr_en_o),
    .fifo_data_o  (fifo_data_o),
    .grant_id_o   (grant_id_o),
    .busy_o       (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: who holds the port, how many words it moved.
  int m_holder;   // -1 when no grant is held
  int m_beats;
  int m_last;
  int m_gid;
  bit m_wr_last;

  // Observations of the DUT for per-scenario summaries.
  logic [DW-1:0] wq[$];
  int            grant_q[$];
  int            blen_q[$];
  int            cur_len;
  bit            prev_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_holder = -1;
    m_beats  = 0;
    m_last   = NR - 1;
    m_gid    = 0;
  endtask

  task automatic clear_obs();
    wq.delete();
    grant_q.delete();
    blen_q.delete();
    cur_len = 0;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model.
  task automatic check_cycle();
    logic          e_busy, e_wr;
    logic [NR-1:0] e_ready;
    logic [DW-1:0] e_data;
    logic [IB-1:0] e_gid;
    bit            found;
    @(negedge clk_i);
    e_busy = 1'b0; e_wr = 1'b0; e_ready = '0; e_data = '0; e_gid = '0;
    if (!rst_i) begin
      e_gid = IB'(m_gid);
      if (m_holder >= 0) begin
        e_busy = 1'b1;
        if (!fifo_full_i) e_ready = NR'(1) << m_holder;
        e_wr = req_valid_i[m_holder] && !fifo_full_i;
        if (e_wr) e_data = req_data_i[m_holder*DW +: DW];
      end
    end
    m_wr_last = e_wr;
    check("wr_en", 64'(fifo_wr_en_o), 64'(e_wr));
    check("data", 64'(fifo_data_o), 64'(e_data));
    check("ready", 64'(req_ready_o), 64'(e_ready));
    check("busy", 64'(busy_o), 64'(e_busy));
    check("grant_id", 64'(grant_id_o), 64'(e_gid));
    check("ready_onehot0", 64'($onehot0(req_ready_o)), 64'd1);
    check("wr_while_full", 64'(fifo_wr_en_o && fifo_full_i), 64'd0);

    if (fifo_wr_en_o) wq.push_back(fifo_data_o);
    if (busy_o && !prev_busy) begin grant_q.push_back(int'(grant_id_o)); cur_len = 0; end
    if (!busy_o && prev_busy) blen_q.push_back(cur_len);
    if (fifo_wr_en_o) cur_len++;
    prev_busy = busy_o;

    if (rst_i) begin
      model_reset();
    end else if (m_holder < 0) begin
      found = 1'b0;
      for (int i = 1; i <= NR; i++) begin
        int k;
        k = (m_last + i) % NR;
        if (!found && req_valid_i[k]) begin
          found = 1'b1; m_holder = k; m_last = k; m_gid = k; m_beats = 0;
        end
      end
    end else if (!req_valid_i[m_holder]) begin
      m_holder = -1;
    end else if (!fifo_full_i) begin
      m_beats++;
      if (m_beats == MB) m_holder = -1;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    check_cycle();
    rst_i = 1'b0;
  endtask

  initial begin
    int word, wrs, full_cnt;
    rst_i = 1'b1; req_valid_i = '0; req_data_i = '0; fifo_full_i = 1'b0;
    prev_busy = 1'b0; m_wr_last = 1'b0;
    model_reset();
    clear_obs();
    @(posedge clk_i); #1;
    check_cycle();
    do_reset();

    // Single requester streaming A0..A3 then releasing.
    clear_obs();
    req_valid_i = 4'b0001;
    word = 0;
    for (int c = 0; c < 12 && word < 4; c++) begin
      req_data_i[DW-1:0] = 64'hA0 + 64'(word);
      check_cycle();
      if (m_wr_last) word++;
    end
    req_valid_i = '0;
    check_cycle(); check_cycle();
    check("s1_nwrites", 64'(wq.size()), 64'd4);
    for (int i = 0; i < 4; i++) check("s1_word", (i < wq.size()) ? wq[i] : 'x, 64'hA0 + 64'(i));
    check("s1_grant", 64'(grant_q.size() > 0 ? grant_q[0] : -1), 64'd0);

    // All requesters saturated: round-robin 0,1,2,3,0 with full bursts.
    do_reset();
    clear_obs();
    req_valid_i = 4'b1111;
    for (int c = 0; c < 46; c++) begin
      for (int r = 0; r < NR; r++) req_data_i[r*DW +: DW] = {$urandom, $urandom};
      check_cycle();
    end
    req_valid_i = '0;
    check_cycle();
    check("s2_nbursts", 64'(blen_q.size() >= 5), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("s2_grant_order", 64'(i < grant_q.size() ? grant_q[i] : -1), 64'(i % NR));
      check("s2_burst_len", 64'(i < blen_q.size() ? blen_q[i] : -1), 64'(MB));
    end

    // Requester 2 stalled by full for three cycles after beat 4.
    do_reset();
    clear_obs();
    req_valid_i = 4'b0100;
    wrs = 0; full_cnt = 0;
    for (int c = 0; c < 40 && wrs < 8; c++) begin
      if (wrs == 4 && full_cnt < 3) begin fifo_full_i = 1'b1; full_cnt++; end
      else fifo_full_i = 1'b0;
      req_data_i[2*DW +: DW] = 64'h2000 + 64'(wrs);
      check_cycle();
      if (m_wr_last) wrs++;
    end
    fifo_full_i = 1'b0;
    req_valid_i = '0;
    check_cycle(); check_cycle();
    check("s3_stall_cycles", 64'(full_cnt), 64'd3);
    check("s3_burst_len", 64'(blen_q.size() > 0 ? blen_q[0] : -1), 64'd8);
    check("s3_grant", 64'(grant_q.size() > 0 ? grant_q[0] : -1), 64'd2);
    check("s3_beat5", (wq.size() > 4) ? wq[4] : 'x, 64'h2004);

    // Lone requester 1 is re-granted after a single idle cycle.
    do_reset();
    clear_obs();
    req_valid_i = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      req_data_i[DW +: DW] = {$urandom, $urandom};
      check_cycle();
    end
    req_valid_i = '0;
    check_cycle(); check_cycle();
    check("s4_regrant_a", 64'(grant_q.size() > 0 ? grant_q[0] : -1), 64'd1);
    check("s4_regrant_b", 64'(grant_q.size() > 1 ? grant_q[1] : -1), 64'd1);
    check("s4_burst_len", 64'(blen_q.size() > 0 ? blen_q[0] : -1), 64'd8);

    // Reset at beat 3 of a requester-1 burst; requester 0 wins afterwards.
    do_reset();
    req_valid_i = 4'b0010;
    wrs = 0;
    for (int c = 0; c < 10 && wrs < 3; c++) begin
      check_cycle();
      if (m_wr_last) wrs++;
    end
    req_valid_i = 4'b1111;
    clear_obs();
    rst_i = 1'b1;
    check_cycle();
    check("s5_no_write_in_reset", 64'(wq.size()), 64'd0);
    rst_i = 1'b0;
    check_cycle(); check_cycle();
    check("s5_next_grant", 64'(grant_q.size() > 0 ? grant_q[0] : -1), 64'd0);
    req_valid_i = '0;
    check_cycle();

    // Random traffic with random back-pressure and rare resets.
    for (int c = 0; c < 800; c++) begin
      for (int r = 0; r < NR; r++) begin
        req_data_i[r*DW +: DW] = {$urandom, $urandom};
        req_valid_i[r] = ($urandom_range(0, 3) != 0);
      end
      fifo_full_i = ($urandom_range(0, 3) == 0);
      rst_i = ($urandom_range(0, 99) == 0);
      check_cycle();
    end
    rst_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64: width of each requester word and of the FIFO write word.
REQ-002 Parameter NUM_REQ, default 4: number of write requesters sharing one sync circular FIFO write port.
REQ-003 Parameter REQ_ID_BITS, default 2: width of grant index, equal to ceil(log2(NUM_REQ)).
REQ-004 Parameter MAX_BURST, default 8: maximum words accepted from one requester per grant.
REQ-005 clk_i  input  1  single clock; all state changes on rising edge.
REQ-006 rst_i  input  1  reset, synchronous and active-high.
REQ-007 req_valid_i  input  NUM_REQ  per-requester word-available flag.
REQ-008 req_data_i  input  NUM_REQ*DATA_WIDTH  requester words, requester k in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_ready_o  output  NUM_REQ  per-requester accept flag; at most one bit high.
REQ-010 fifo_full_i  input  1  FIFO full flag.
REQ-011 fifo_wr_en_o  output  1  FIFO write strobe.
REQ-012 fifo_data_o  output  DATA_WIDTH  FIFO write data.
REQ-013 grant_id_o  output  REQ_ID_BITS  index of current grant holder (valid when busy_o=1).
REQ-014 busy_o  output  1  high while a grant is held.

Function
REQ-015 FSM SHALL have exactly two states: IDLE and BURST.
REQ-016 IDLE: if any req_valid_i bit is high, the block SHALL register grant_id = first requester with valid high searching upward (modulo NUM_REQ) from last_grant+1, update last_grant to it, clear beat_cnt, and enter BURST next cycle; no transfer occurs in the IDLE cycle.
REQ-017 IDLE with no valid bit high: remain IDLE, last_grant unchanged.
REQ-018 BURST: req_ready_o[grant_id] SHALL equal ~fifo_full_i combinationally; all other ready bits 0.
REQ-019 BURST transfer: when req_valid_i[grant_id] & ~fifo_full_i, fifo_wr_en_o=1 and fifo_data_o=requester grant_id word in the same cycle (zero latency), beat_cnt increments.
REQ-020 fifo_wr_en_o SHALL be 0 in IDLE and whenever fifo_full_i=1; fifo_data_o SHALL be 0 when fifo_wr_en_o=0.
REQ-021 FIFO full in BURST: hold state, grant and beat_cnt; no timeout.
REQ-022 Burst end by length: transfer with beat_cnt=MAX_BURST-1 -> IDLE next cycle.
REQ-023 Burst end by release: req_valid_i[grant_id]=0 in BURST -> IDLE next cycle, no write.
REQ-024 A requester SHALL NOT be granted twice consecutively while another requester has valid high at the IDLE decision.
REQ-025 beat_cnt width SHALL be ceil(log2(MAX_BURST))+1; it never exceeds MAX_BURST-1 before reset.
REQ-026 busy_o=1 exactly in BURST; grant_id_o reflects registered grant.

Reset
REQ-027 rst_i high at a clock edge SHALL force IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), beat_cnt=0, grant_id=0.
REQ-028 During reset all outputs SHALL be 0; reset mid-burst aborts with no write in the reset cycle.

Structure
REQ-029 Package fifo_arb_pkg SHALL hold the state encodings (IDLE=1'b0, BURST=1'b1) and default parameter constants.
REQ-030 Sub-module rr_priority_picker (combinational: valid vector + last_grant -> next index + any_valid) SHALL implement the round-robin search.

Verification
REQ-031 After reset, req_valid_i=4'b0001, data 0xA0..0xA3, full=0 -> grant 0 next cycle, four writes 0xA0..0xA3 on consecutive cycles, then IDLE on valid drop.
REQ-032 All four valid continuously, full=0 -> grants 0,1,2,3,0 in order, each burst exactly 8 writes, one idle cycle between bursts.
REQ-033 Requester 2 bursting, fifo_full_i high for 3 cycles after beat 4 -> no writes, ready low for 3 cycles, resume with beat 5, burst total 8.
REQ-034 Only requester 1 valid, burst length 8 done -> requester 1 re-granted after one IDLE cycle.
REQ-035 rst_i asserted mid-burst at beat 3 -> fifo_wr_en_o=0 that cycle, next grant after release is requester 0.
REQ-036 Every cycle: at most one req_ready_o bit high, fifo_wr_en_o implies ~fifo_full_i.
